// File: rtl/memmu_pointcloud_pkg.sv
// ---------------------------------------------------------------------------
// memmu_pointcloud_pkg
// Shared definitions for the multi-channel MemMU pointcloud writer:
//   - BYTES_PER_POINT : size of one packed point in DDR
//   - pointPayload_t  : 64-bit packed point {angleV, angleH, label, reflR0, distR0}
//   - chState_e       : per-channel lifecycle state
//   - pointAddr()     : byte address of a point inside a ping-pong frame bank
// No ports (package).
// ---------------------------------------------------------------------------
package memmu_pointcloud_pkg;

    localparam int BYTES_PER_POINT = 8;

    // Declared MSB first so the packed layout is {angleV,angleH,label,reflR0,distR0}.
    typedef struct packed {
        logic [15:0] angleV;
        logic [15:0] angleH;
        logic [7:0]  label;
        logic [7:0]  reflR0;
        logic [15:0] distR0;
    } pointPayload_t;

    // S_IDLE  : channel has never seen a point
    // S_FILL  : first frame being written, nothing completed yet
    // S_STEADY: at least one frame completed, reads are serviceable
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STEADY = 2'd2
    } chState_e;

    // base + bank*stride + idx*BYTES_PER_POINT, wrapping modulo 2^32.
    function automatic logic [31:0] pointAddr(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic        bank,
        input logic [31:0] idx
    );
        logic [31:0] bankOffset;
        bankOffset = bank ? stride : 32'd0;
        return base + bankOffset + (idx * 32'(BYTES_PER_POINT));
    endfunction

endpackage

// File: rtl/memmu_pointcloud_mc_if.sv
// ---------------------------------------------------------------------------
// memmu_pointcloud_mc_if
// Bundles the three handshake buses around the MemMU pointcloud writer:
//   SIU point stream  : siuValid/siuReady + point fields
//   DDR write request : writeValid/writeReady + writeAddress/writePayload
//   ExMU read lookup  : readValid/readChannel/pointReadID -> rspValid/rspAddress/rspError
// Modports:
//   slave  - the MemMU (consumes points and read requests, produces writes)
//   master - the surrounding system (SIU, DDR port, ExMU)
// ---------------------------------------------------------------------------
interface memmu_pointcloud_mc_if #(
    parameter int CH_W  = 2,
    parameter int IDX_W = 19
);
    // SIU point stream
    logic             siuValid;
    logic             siuReady;
    logic [CH_W-1:0]  siuChannel;
    logic             siuNewFrame;
    logic [15:0]      siuAngleH;
    logic [15:0]      siuAngleV;
    logic [15:0]      siuDistR0;
    logic [7:0]       siuReflR0;
    logic [7:0]       siuLabel;

    // DDR write request
    logic             writeValid;
    logic             writeReady;
    logic [31:0]      writeAddress;
    logic [63:0]      writePayload;

    // ExMU read translation
    logic             readValid;
    logic [CH_W-1:0]  readChannel;
    logic [IDX_W-1:0] pointReadID;
    logic             rspValid;
    logic [31:0]      rspAddress;
    logic             rspError;

    modport slave (
        input  siuValid, siuChannel, siuNewFrame, siuAngleH, siuAngleV,
               siuDistR0, siuReflR0, siuLabel,
        output siuReady,
        output writeValid, writeAddress, writePayload,
        input  writeReady,
        input  readValid, readChannel, pointReadID,
        output rspValid, rspAddress, rspError
    );

    modport master (
        output siuValid, siuChannel, siuNewFrame, siuAngleH, siuAngleV,
               siuDistR0, siuReflR0, siuLabel,
        input  siuReady,
        input  writeValid, writeAddress, writePayload,
        output writeReady,
        output readValid, readChannel, pointReadID,
        input  rspValid, rspAddress, rspError
    );

endinterface

// File: rtl/memmu_skid_buffer.sv
// ---------------------------------------------------------------------------
// memmu_skid_buffer
// Two-entry valid/ready register slice. Data pushed on an edge appears on the
// output after that edge; the head entry stays put while outValid & !outReady.
// inReady is registered: it is high whenever at least one entry will be free
// in the coming cycle, so a steady stream of 1 item/cycle passes while the
// consumer is ready, and the producer sees ready fall after two pushes into a
// stalled consumer.
// Ports:
//   i_SYSTEM_clk / i_SYSTEM_rst  clock, asynchronous active-low reset
//   inValid/inReady/inData       upstream handshake
//   outValid/outReady/outData    downstream handshake
// Parameter WIDTH: payload width in bits.
// ---------------------------------------------------------------------------
module memmu_skid_buffer #(
    parameter int WIDTH = 96
) (
    input  logic             i_SYSTEM_clk,
    input  logic             i_SYSTEM_rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData
);

    logic [WIDTH-1:0] entryData [2];
    logic [1:0]       countReg;
    logic [1:0]       countNext;
    logic             wrPtrReg;
    logic             rdPtrReg;
    logic             readyReg;
    logic             push;
    logic             pop;

    assign push     = inValid & readyReg;
    assign pop      = outValid & outReady;
    assign outValid = (countReg != 2'd0);
    assign outData  = entryData[rdPtrReg];
    assign inReady  = readyReg;

    always_comb begin
        countNext = countReg;
        case ({push, pop})
            2'b10:   countNext = countReg + 2'd1;
            2'b01:   countNext = countReg - 2'd1;
            default: countNext = countReg;
        endcase
    end

    // Entries are cleared too so that reset shows an all-zero bus.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            countReg     <= 2'd0;
            wrPtrReg     <= 1'b0;
            rdPtrReg     <= 1'b0;
            readyReg     <= 1'b0;
            entryData[0] <= '0;
            entryData[1] <= '0;
        end else begin
            countReg <= countNext;
            readyReg <= (countNext != 2'd2);
            if (push) begin
                entryData[wrPtrReg] <= inData;
                wrPtrReg            <= ~wrPtrReg;
            end
            if (pop) begin
                rdPtrReg <= ~rdPtrReg;
            end
        end
    end

endmodule

// File: rtl/memmu_pointcloud_mc.sv
// ---------------------------------------------------------------------------
// memmu_pointcloud_mc
// Multi-channel MemMU address/payload generator between SIU and the DDR
// write port. Every channel owns a ping-pong pair of frame banks; each
// accepted SIU point is packed into 64 bits and written at
//   base[ch] + bank[ch]*FRAME_STRIDE + idx[ch]*8.
// A newFrame point closes the current bank (frameDone pulse with its size)
// and starts the other one. ExMU read IDs are translated into addresses in
// the most recently completed bank of the requested channel.
// Ports:
//   i_SYSTEM_clk, i_SYSTEM_rst (async, active-low)
//   i_MonU_baseAddr    per-channel DDR base, channel k at [32k +: 32]
//   bus                memmu_pointcloud_mc_if.slave (SIU / DDR write / ExMU read)
//   o_MemMU_frameDone  one-cycle pulse, with o_MemMU_frameCh/o_MemMU_frameSize
//   o_MemMU_overflow   per-channel sticky overflow, cleared by next newFrame
// Optional build macro MEMMU_PC_DROP_COUNT_EN adds o_MemMU_dropCount
// (16 bits per channel, saturating count of overflow-dropped points).
// ---------------------------------------------------------------------------
module memmu_pointcloud_mc
    import memmu_pointcloud_pkg::*;
#(
    parameter int               NUM_CHANNELS = 4,
    parameter int               CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int               IDX_W        = 19,
    parameter logic [IDX_W-1:0] MAX_POINTS   = IDX_W'(131072),
    parameter logic [31:0]      FRAME_STRIDE = 32'h0010_0000
) (
    input  logic                      i_SYSTEM_clk,
    input  logic                      i_SYSTEM_rst,
    input  logic [32*NUM_CHANNELS-1:0] i_MonU_baseAddr,
    memmu_pointcloud_mc_if.slave      bus,
    output logic                      o_MemMU_frameDone,
    output logic [CH_W-1:0]           o_MemMU_frameCh,
    output logic [IDX_W-1:0]          o_MemMU_frameSize,
    output logic [NUM_CHANNELS-1:0]   o_MemMU_overflow
`ifdef MEMMU_PC_DROP_COUNT_EN
    ,
    output logic [16*NUM_CHANNELS-1:0] o_MemMU_dropCount
`endif
);

    localparam int ENTRY_W = 32 + $bits(pointPayload_t);

    // Per-channel state, exported from the generate blocks for muxing.
    chState_e         stateArr [NUM_CHANNELS];
    logic             bankArr  [NUM_CHANNELS];
    logic [IDX_W-1:0] idxArr   [NUM_CHANNELS];
    logic [IDX_W-1:0] sizeArr  [NUM_CHANNELS];

    // Write-side view of the addressed channel
    logic             wrChValid;
    chState_e         wrState;
    logic             wrBankCur;
    logic [IDX_W-1:0] wrIdxCur;
    logic [31:0]      wrBase;

    // Read-side view of the addressed channel
    logic             rdChValid;
    chState_e         rdState;
    logic             rdBank;
    logic [IDX_W-1:0] rdSize;
    logic [31:0]      rdBase;

    logic             siuReady;
    logic             pointAccept;
    logic             isNewFrame;
    logic             dropPoint;
    logic             closeFrame;
    logic [31:0]      wrAddr;
    pointPayload_t    wrPayload;

    logic               skidOutValid;
    logic [ENTRY_W-1:0] skidOutData;

    logic             frameDoneReg;
    logic [CH_W-1:0]  frameChReg;
    logic [IDX_W-1:0] frameSizeReg;

    logic             rspValidReg;
    logic [31:0]      rspAddrReg;
    logic             rspErrReg;

    // Channel select. Indices >= NUM_CHANNELS match nothing and leave the
    // *ChValid flags low, which drops the point / errors the read.
    always_comb begin
        wrChValid = 1'b0;
        wrState   = S_IDLE;
        wrBankCur = 1'b0;
        wrIdxCur  = '0;
        wrBase    = '0;
        rdChValid = 1'b0;
        rdState   = S_IDLE;
        rdBank    = 1'b0;
        rdSize    = '0;
        rdBase    = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (bus.siuChannel == CH_W'(k)) begin
                wrChValid = 1'b1;
                wrState   = stateArr[k];
                wrBankCur = bankArr[k];
                wrIdxCur  = idxArr[k];
                wrBase    = i_MonU_baseAddr[32*k +: 32];
            end
            if (bus.readChannel == CH_W'(k)) begin
                rdChValid = 1'b1;
                rdState   = stateArr[k];
                rdBank    = bankArr[k];
                rdSize    = sizeArr[k];
                rdBase    = i_MonU_baseAddr[32*k +: 32];
            end
        end
    end

    assign pointAccept = bus.siuValid & siuReady;
    // A newFrame flag on a channel's very first point just starts filling.
    assign isNewFrame  = (wrState != S_IDLE) & bus.siuNewFrame;
    assign dropPoint   = ~wrChValid | (~isNewFrame & (wrIdxCur >= MAX_POINTS));
    assign closeFrame  = pointAccept & wrChValid & isNewFrame;

    // A closing point lands at index 0 of the opposite bank.
    assign wrAddr = pointAddr(wrBase, FRAME_STRIDE,
                              isNewFrame ? ~wrBankCur : wrBankCur,
                              isNewFrame ? 32'd0 : 32'(wrIdxCur));

    always_comb begin
        wrPayload        = '0;
        wrPayload.angleV = bus.siuAngleV;
        wrPayload.angleH = bus.siuAngleH;
        wrPayload.label  = bus.siuLabel;
        wrPayload.reflR0 = bus.siuReflR0;
        wrPayload.distR0 = bus.siuDistR0;
    end

    // Dropped points are still handshaken on the SIU side but never pushed.
    memmu_skid_buffer #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .i_SYSTEM_clk (i_SYSTEM_clk),
        .i_SYSTEM_rst (i_SYSTEM_rst),
        .inValid      (bus.siuValid & ~dropPoint),
        .inReady      (siuReady),
        .inData       ({wrAddr, wrPayload}),
        .outValid     (skidOutValid),
        .outReady     (bus.writeReady),
        .outData      (skidOutData)
    );

    assign bus.siuReady     = siuReady;
    assign bus.writeValid   = skidOutValid;
    assign bus.writeAddress = skidOutData[ENTRY_W-1 -: 32];
    assign bus.writePayload = skidOutData[63:0];

    // Per-channel frame bookkeeping
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            chState_e         stateReg;
            logic             bankReg;
            logic [IDX_W-1:0] idxReg;
            logic [IDX_W-1:0] sizeReg;
            logic             overflowReg;
            logic             hit;
            logic             ovDrop;

            assign hit    = pointAccept & (bus.siuChannel == CH_W'(gi));
            assign ovDrop = hit & (stateReg != S_IDLE) & ~bus.siuNewFrame
                          & (idxReg >= MAX_POINTS);

            always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
                if (!i_SYSTEM_rst) begin
                    stateReg    <= S_IDLE;
                    bankReg     <= 1'b0;
                    idxReg      <= '0;
                    sizeReg     <= '0;
                    overflowReg <= 1'b0;
                end else if (hit) begin
                    if (stateReg == S_IDLE) begin
                        stateReg <= S_FILL;
                        idxReg   <= idxReg + IDX_W'(1);
                    end else if (bus.siuNewFrame) begin
                        stateReg    <= S_STEADY;
                        bankReg     <= ~bankReg;
                        sizeReg     <= idxReg;
                        overflowReg <= 1'b0;
                        idxReg      <= IDX_W'(1);
                    end else if (ovDrop) begin
                        overflowReg <= 1'b1;
                    end else begin
                        idxReg <= idxReg + IDX_W'(1);
                    end
                end
            end

            assign stateArr[gi]         = stateReg;
            assign bankArr[gi]          = bankReg;
            assign idxArr[gi]           = idxReg;
            assign sizeArr[gi]          = sizeReg;
            assign o_MemMU_overflow[gi] = overflowReg;

`ifdef MEMMU_PC_DROP_COUNT_EN
            logic [15:0] dropCountReg;

            always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
                if (!i_SYSTEM_rst) begin
                    dropCountReg <= '0;
                end else if (ovDrop && (dropCountReg != 16'hFFFF)) begin
                    dropCountReg <= dropCountReg + 16'd1;
                end
            end

            assign o_MemMU_dropCount[16*gi +: 16] = dropCountReg;
`endif
        end
    endgenerate

    // Frame-close notification, one cycle after the closing point.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            frameDoneReg <= 1'b0;
            frameChReg   <= '0;
            frameSizeReg <= '0;
        end else begin
            frameDoneReg <= closeFrame;
            if (closeFrame) begin
                frameChReg   <= bus.siuChannel;
                frameSizeReg <= wrIdxCur;
            end
        end
    end

    assign o_MemMU_frameDone = frameDoneReg;
    assign o_MemMU_frameCh   = frameChReg;
    assign o_MemMU_frameSize = frameSizeReg;

    // Read translation. Uses the pre-edge bank/size, so a read in the same
    // cycle as a closing point still targets the previously completed bank.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            rspValidReg <= 1'b0;
            rspAddrReg  <= '0;
            rspErrReg   <= 1'b0;
        end else begin
            rspValidReg <= bus.readValid;
            if (bus.readValid) begin
                rspAddrReg <= pointAddr(rdBase, FRAME_STRIDE, ~rdBank,
                                        32'(bus.pointReadID));
                rspErrReg  <= ~rdChValid | (rdState != S_STEADY)
                            | (bus.pointReadID >= rdSize);
            end
        end
    end

    assign bus.rspValid   = rspValidReg;
    assign bus.rspAddress = rspAddrReg;
    assign bus.rspError   = rspErrReg;

endmodule
